// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: datapath widths,
// PC increment, default reset PC, FSM state encoding and FIFO entry layout.
package inst_fetch_ctrl_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RESET_WAIT: first cycle after reset release, nothing is issued.
    // RUN: normal issuing. FLUSH: the cycle right after a redirect was taken.
    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction memory is word addressed; the two byte-offset bits are forced to zero.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bus bundle of the fetch controller: instruction-memory port, redirect
// request and the fetched-instruction output stream.
//
// Output stream handshake: out_valid says out_inst/out_pc carry a fetched
// instruction; the entry is consumed on a rising clk edge where out_valid and
// out_ready are both 1. out_valid never depends combinationally on out_ready,
// and the producer keeps out_inst/out_pc stable until the entry is consumed
// (or the stream is flushed by a redirect or reset).
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    // The fetch controller side.
    modport master (
        output imem_addr, out_valid, out_inst, out_pc,
        input  imem_inst, redirect, redirect_pc, out_ready
    );

    // The environment side: memory, redirect source and consumer.
    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc,
        output imem_inst, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small output buffer for fetched instructions: synchronous push/pop/flush,
// occupancy count, head entry shown combinationally (zero when empty).
module fetch_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count
);

    localparam int            PW   = (DEPTH > 2) ? 2 : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = (count != '0) ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to a synchronous
// instruction memory, buffers returned instructions with their PCs and
// presents them as a valid/ready stream. Redirects flush everything fetched
// so far and restart fetching at the new target.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_ctrl_if.master bus,
    output fetch_state_e      dbg_state
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   occupancy;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Buffered plus in-flight instructions; issuing only while this is below
    // the buffer depth guarantees every response has a free slot. Only
    // registered values feed it, so out_ready never reaches imem_addr.
    assign occupancy  = fifo_count + CW'(inflight);
    assign issue      = !bus.redirect && (state != RESET_WAIT) && (occupancy < DEPTH_C);
    // A response arriving in a redirect cycle belongs to the abandoned path.
    assign push       = inflight && !bus.redirect;
    assign pop        = bus.out_valid && bus.out_ready;
    assign push_entry = '{pc: resp_pc, inst: bus.imem_inst};

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
    assign dbg_state     = state;

    // Fetch FSM together with the fetch PC and the response-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_WAIT;
            fetch_pc <= word_align(RESET_PC);
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            state    <= FLUSH;
            fetch_pc <= word_align(bus.redirect_pc);
            inflight <= 1'b0;
        end else begin
            state    <= RUN;
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_INC;
                resp_pc  <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (bus.redirect),
        .dout  (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus a randomized phase,
// checked each cycle against a stream-level reference model.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int          DEPTH  = 3;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    fetch_state_e dbg_state;

    inst_fetch_ctrl_if ifc ();

    inst_fetch_ctrl #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Synchronous instruction memory preloaded with word[n] = n.
    always @(posedge clk) ifc.imem_inst <= ifc.imem_addr >> 2;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    int          since    = 0;   // cycles since last reset release / redirect
    bit          after_redirect = 1'b0;
    logic [31:0] exp_q[$];       // upcoming PCs the consumer must see, in order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // New sequential stream starting at the aligned target.
    task automatic restart(input logic [31:0] target);
        logic [31:0] a;
        a = target & 32'hFFFF_FFFC;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    // Per-cycle comparison against the stream model.
    task automatic check_cycle(input bit exp_valid);
        logic [31:0] lead;
        logic [31:0] exp_state;
        check("out_valid", 32'(ifc.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", ifc.out_pc, exp_q[0]);
            check("out_inst", ifc.out_inst, exp_q[0] >> 2);
        end
        // Fetch address runs ahead of the consumer by issued-but-unconsumed words.
        lead = ifc.imem_addr - exp_q[0];
        if (since == 1)      check("imem_lead", lead, 32'd0);
        else if (since == 2) check("imem_lead", lead, 32'd4);
        else                 check("imem_lead_ok", 32'((lead == 32'd8) || (lead == 32'd12)), 32'd1);
        exp_state = (since == 1 && after_redirect) ? 32'(FLUSH) : 32'(RUN);
        check("state", 32'(dbg_state), exp_state);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rdir, input logic [31:0] tgt, input bit rdy);
        bit exp_valid;
        @(posedge clk);
        since++;
        @(negedge clk);
        exp_valid = (since >= 3);
        check_cycle(exp_valid);
        ifc.redirect    = rdir;
        ifc.redirect_pc = tgt;
        ifc.out_ready   = rdy;
        if (rdir) begin
            restart(tgt);
            since          = 0;
            after_redirect = 1'b1;
        end else if (exp_valid && rdy) begin
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[$] + 32'd4);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_inst"}, ifc.out_inst, 32'd0);
        check({tag, "_pc"}, ifc.out_pc, 32'd0);
        check({tag, "_imem_addr"}, ifc.imem_addr, RST_PC);
        check({tag, "_state"}, 32'(dbg_state), 32'(RESET_WAIT));
    endtask

    task automatic apply_reset();
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'd0;
        ifc.out_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n          = 1'b1;
        since          = 0;
        after_redirect = 1'b0;
        restart(RST_PC);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n           = 1'b0;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'd0;
        ifc.out_ready   = 1'b0;

        // Streaming from reset with the consumer always ready.
        apply_reset();
        repeat (20) cycle(1'b0, 32'd0, 1'b1);

        // Consumer stalled after reset: buffer fills, fetch address holds.
        apply_reset();
        repeat (10) cycle(1'b0, 32'd0, 1'b0);
        check("stall_imem_addr", ifc.imem_addr, 32'h0000_000C);
        check("stall_head_pc", ifc.out_pc, 32'h0000_0000);
        repeat (8) cycle(1'b0, 32'd0, 1'b1);

        // Redirect to an unaligned target while the buffer is full.
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0102, 1'b0);
        repeat (3) cycle(1'b0, 32'd0, 1'b1);
        check("redirect_first_pc", ifc.out_pc, 32'h0000_0100);
        repeat (5) cycle(1'b0, 32'd0, 1'b1);

        // Redirect near the top of the address space: PC wraps to zero.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (8) cycle(1'b0, 32'd0, 1'b1);

        // Back-to-back redirects: only the second stream appears.
        cycle(1'b1, 32'h0000_0040, 1'b1);
        cycle(1'b1, 32'h0000_0080, 1'b1);
        repeat (3) cycle(1'b0, 32'd0, 1'b1);
        check("b2b_first_pc", ifc.out_pc, 32'h0000_0080);
        repeat (4) cycle(1'b0, 32'd0, 1'b1);

        // Random consumer back-pressure and random redirects.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset pulse between clock edges mid-stream.
        repeat (6) cycle(1'b0, 32'd0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #1 rst_n = 1'b1;
        since          = 0;
        after_redirect = 1'b0;
        restart(RST_PC);
        repeat (12) cycle(1'b0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
